// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: one trace record per retired instruction.
package commit_trace_buffer_pkg;
    localparam int TRACE_SEQ_WIDTH = 16;

    typedef logic [31:0]                pc_t;
    typedef logic [TRACE_SEQ_WIDTH-1:0] seq_t;

    typedef struct packed {
        pc_t         pc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] wdata;
        seq_t        seq;
    } commit_trace_t;
endpackage

// File: rtl/commit_trace_buffer_if.sv
// ROB commit lanes plus the trace sink handshake; master drives commits/ready, slave is the buffer.
interface commit_trace_buffer_if
    import commit_trace_buffer_pkg::*;
#(parameter int COMMIT_WIDTH = 2);
    logic [COMMIT_WIDTH-1:0]       commit_valid;
    logic [COMMIT_WIDTH-1:0][31:0] commit_pc;
    logic [COMMIT_WIDTH-1:0][4:0]  commit_rd;
    logic [COMMIT_WIDTH-1:0]       commit_wen;
    logic [COMMIT_WIDTH-1:0][31:0] commit_wdata;
    logic                          stall_req;
    logic                          trace_valid;
    logic                          trace_ready;
    commit_trace_t                 trace_rec;

    modport master (output commit_valid, commit_pc, commit_rd, commit_wen, commit_wdata, trace_ready,
                    input  stall_req, trace_valid, trace_rec);
    modport slave  (input  commit_valid, commit_pc, commit_rd, commit_wen, commit_wdata, trace_ready,
                    output stall_req, trace_valid, trace_rec);
endinterface

// File: rtl/commit_trace_buffer_lane_compactor.sv
// Prefix-sum over the valid mask: each lane gets its slot among valid lanes; only the first `free` are accepted.
module commit_lane_compactor #(
    parameter int W  = 2,
    parameter int FW = 5,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         valid,
    input  logic [FW-1:0]        free,
    output logic [W-1:0]         accept,
    output logic [W-1:0][CW-1:0] slot,
    output logic [CW-1:0]        total,
    output logic [CW-1:0]        accepted
);
    always_comb begin
        logic [CW-1:0] run;
        run      = '0;
        accepted = '0;
        accept   = '0;
        slot     = '0;
        for (int i = 0; i < W; i++) begin
            slot[i]   = run;
            accept[i] = valid[i] && (32'(run) < 32'(free));
            run       = run + CW'(valid[i]);
            accepted  = accepted + CW'(accept[i]);
        end
        total = run;
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// Compacts up to COMMIT_WIDTH retired instructions per cycle into a FIFO and drains one record per cycle.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int DEPTH        = 16,
    parameter int DROP_MODE    = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    commit_trace_buffer_if.slave              bus,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_count,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic [31:0]                       drop_count
);
    localparam int CW = $clog2(COMMIT_WIDTH + 1);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    commit_trace_t                   mem [DEPTH];
    logic [PW-1:0]                   head, tail;
    logic [OW-1:0]                   occ, free, push_room;
    seq_t                            seq;
    logic                            pop;
    logic [COMMIT_WIDTH-1:0]         accept;
    logic [COMMIT_WIDTH-1:0][CW-1:0] slot;
    logic [CW-1:0]                   total, accepted, dropped;
    logic [32:0]                     drop_sum;
    logic [31:0]                     drop_next;

    // Free space ignores a same-cycle pop so stall_req never depends on trace_ready.
    assign free          = OW'(DEPTH) - occ;
    assign bus.stall_req = (DROP_MODE == 0) && (free < OW'(COMMIT_WIDTH));
    assign push_room     = bus.stall_req ? '0 : free;

    commit_lane_compactor #(.W(COMMIT_WIDTH), .FW(OW), .CW(CW)) u_compact (
        .valid    (bus.commit_valid),
        .free     (push_room),
        .accept   (accept),
        .slot     (slot),
        .total    (total),
        .accepted (accepted)
    );

    assign dropped         = total - accepted;
    assign drop_sum        = {1'b0, drop_count} + 33'(dropped);
    assign drop_next       = drop_sum[32] ? '1 : drop_sum[31:0];
    assign bus.trace_valid = (occ != '0);
    assign bus.trace_rec   = bus.trace_valid ? mem[head] : '0;
    assign pop             = bus.trace_valid && bus.trace_ready;
    assign occupancy       = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            occ          <= '0;
            seq          <= '0;
            drop_count   <= '0;
            commit_count <= '0;
        end else begin
            commit_count <= total;
            if (flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                head       <= head + PW'(pop);
                tail       <= tail + PW'(accepted);
                occ        <= occ + OW'(accepted) - OW'(pop);
                // Every presented record consumes a seq number, so drops show up as gaps at the sink.
                seq        <= seq + seq_t'(total);
                drop_count <= drop_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (accept[i])
                    mem[tail + PW'(slot[i])] <= '{pc:    bus.commit_pc[i],
                                                  rd:    bus.commit_rd[i],
                                                  wen:   bus.commit_wen[i],
                                                  wdata: bus.commit_wdata[i],
                                                  seq:   seq + seq_t'(slot[i])};
            end
        end
    end

    a_no_retire_while_stalled: assert property (@(posedge clk) disable iff (rst)
        !(bus.stall_req && !flush && (|bus.commit_valid)));
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Drives a 2-lane stalling buffer and a 4-lane dropping buffer against a queue-style reference model.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_trace_buffer_if #(.COMMIT_WIDTH(2)) if0 ();
    commit_trace_buffer_if #(.COMMIT_WIDTH(4)) if1 ();

    logic        fl   [2];
    logic        rdy  [2];
    logic [3:0]  mv   [2];
    logic [3:0]  wens [2];
    logic [31:0] pcs  [2][4];
    logic [4:0]  rds  [2][4];
    logic [31:0] wds  [2][4];

    logic [1:0]  cc0;
    logic [2:0]  cc1;
    logic [4:0]  occ0, occ1;
    logic [31:0] dc0, dc1;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        if (i < 2) begin : g_l0
            assign if0.commit_valid[i] = mv[0][i];
            assign if0.commit_pc[i]    = pcs[0][i];
            assign if0.commit_rd[i]    = rds[0][i];
            assign if0.commit_wen[i]   = wens[0][i];
            assign if0.commit_wdata[i] = wds[0][i];
        end
        assign if1.commit_valid[i] = mv[1][i];
        assign if1.commit_pc[i]    = pcs[1][i];
        assign if1.commit_rd[i]    = rds[1][i];
        assign if1.commit_wen[i]   = wens[1][i];
        assign if1.commit_wdata[i] = wds[1][i];
    end
    assign if0.trace_ready = rdy[0];
    assign if1.trace_ready = rdy[1];

    commit_trace_buffer #(.COMMIT_WIDTH(2), .DEPTH(16), .DROP_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(fl[0]), .bus(if0),
        .commit_count(cc0), .occupancy(occ0), .drop_count(dc0));
    commit_trace_buffer #(.COMMIT_WIDTH(4), .DEPTH(16), .DROP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .bus(if1),
        .commit_count(cc1), .occupancy(occ1), .drop_count(dc1));

    // Reference model: ordered list of pending records, shifted down on every pop.
    int          W  [2] = '{2, 4};
    int          DM [2] = '{0, 1};
    logic [85:0] mq   [2][16];
    int          mcnt [2];
    logic [15:0] mseq [2];
    logic [31:0] mdrop[2];
    int          mcc  [2];
    int          checks = 0;
    int          errors = 0;

    function automatic logic mstall(int d);
        return (DM[d] == 0) && ((16 - mcnt[d]) < W[d]);
    endfunction

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; mseq[d] = '0; mdrop[d] = '0; mcc[d] = 0;
        end
    endtask

    task automatic model_step(int d);
        int nv, acc, cap;
        nv = 0; acc = 0;
        mcc[d] = 0;
        for (int i = 0; i < W[d]; i++) mcc[d] += int'(mv[d][i]);
        if (fl[d]) begin
            mcnt[d] = 0;
            return;
        end
        cap = mstall(d) ? 0 : 16 - mcnt[d];
        if (mcnt[d] > 0 && rdy[d]) begin
            for (int k = 0; k < 15; k++) mq[d][k] = mq[d][k+1];
            mcnt[d]--;
        end
        for (int i = 0; i < W[d]; i++) begin
            if (mv[d][i]) begin
                if (acc < cap) begin
                    mq[d][mcnt[d]] = {pcs[d][i], rds[d][i], wens[d][i], wds[d][i], 16'(int'(mseq[d]) + nv)};
                    mcnt[d]++;
                    acc++;
                end else if (mdrop[d] != 32'hFFFF_FFFF) begin
                    mdrop[d]++;
                end
                nv++;
            end
        end
        mseq[d] = 16'(int'(mseq[d]) + nv);
    endtask

    task automatic chk(string name, int d, logic [85:0] act, logic [85:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic check(int d);
        logic        tv, st;
        logic [85:0] rec;
        int          occ, cc;
        logic [31:0] dc;
        if (d == 0) begin
            tv = if0.trace_valid; st = if0.stall_req; rec = if0.trace_rec;
            occ = int'(occ0); cc = int'(cc0); dc = dc0;
        end else begin
            tv = if1.trace_valid; st = if1.stall_req; rec = if1.trace_rec;
            occ = int'(occ1); cc = int'(cc1); dc = dc1;
        end
        chk("trace_valid", d, 86'(tv), 86'(mcnt[d] != 0));
        chk("trace_rec", d, rec, (mcnt[d] != 0) ? mq[d][0] : 86'(0));
        chk("occupancy", d, 86'(occ), 86'(mcnt[d]));
        chk("drop_count", d, 86'(dc), 86'(mdrop[d]));
        chk("commit_count", d, 86'(cc), 86'(mcc[d]));
        chk("stall_req", d, 86'(st), 86'(mstall(d)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check(0);
        check(1);
        @(negedge clk);
    endtask

    task automatic idle(int d);
        mv[d] = '0; fl[d] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pcs[d][i] = $urandom; rds[d][i] = 5'($urandom_range(0, 31)); wds[d][i] = $urandom;
        end
        wens[d] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        idle(0); idle(1); rdy[0] = 1'b0; rdy[1] = 1'b0;
        mreset();
        @(posedge clk); #1;
        check(0); check(1);
        chk("reset_occ_lit", 0, 86'(occ0), 86'(0));
        chk("reset_drop_lit", 1, 86'(dc1), 86'(0));
        @(negedge clk); rst = 1'b0;

        // Two lanes in one cycle drain on consecutive cycles in lane order.
        mv[0] = 4'b0011; pcs[0][0] = 32'h100; pcs[0][1] = 32'h104; rdy[0] = 1'b1;
        tick();
        chk("t1_pc0", 0, 86'(if0.trace_rec.pc), 86'(32'h100));
        chk("t1_seq0", 0, 86'(if0.trace_rec.seq), 86'(0));
        chk("t1_occ", 0, 86'(occ0), 86'(2));
        idle(0);
        tick();
        chk("t1_pc1", 0, 86'(if0.trace_rec.pc), 86'(32'h104));
        chk("t1_seq1", 0, 86'(if0.trace_rec.seq), 86'(1));
        tick();
        chk("t1_empty", 0, 86'(if0.trace_valid), 86'(0));
        rdy[0] = 1'b0;

        // Sparse mask on four lanes is squeezed.
        mv[1] = 4'b1010;
        pcs[1][0] = 32'hA0; pcs[1][1] = 32'hA4; pcs[1][2] = 32'hA8; pcs[1][3] = 32'hAC;
        tick();
        chk("t2_occ", 1, 86'(occ1), 86'(2));
        chk("t2_cc", 1, 86'(cc1), 86'(2));
        chk("t2_pc_a1", 1, 86'(if1.trace_rec.pc), 86'(32'hA4));
        idle(1); rdy[1] = 1'b1;
        tick();
        chk("t2_pc_a3", 1, 86'(if1.trace_rec.pc), 86'(32'hAC));
        tick();
        rdy[1] = 1'b0;

        // Stall mode: fill to 15 with the sink blocked.
        for (int k = 0; k < 7; k++) begin mv[0] = 4'b0011; tick(); end
        mv[0] = 4'b0001; tick();
        chk("t3_stall", 0, 86'(if0.stall_req), 86'(1));
        chk("t3_occ", 0, 86'(occ0), 86'(15));
        idle(0); tick(); tick();
        chk("t3_drop", 0, 86'(dc0), 86'(0));
        rdy[0] = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        chk("t3_drained", 0, 86'(occ0), 86'(0));
        rdy[0] = 1'b0;

        // Drop mode: overflow at occupancy 15, then full with a pop gets no credit.
        for (int k = 0; k < 3; k++) begin mv[1] = 4'b1111; tick(); end
        mv[1] = 4'b0111; tick();
        mv[1] = 4'b0011; tick();
        chk("t4_drop", 1, 86'(dc1), 86'(1));
        chk("t4_occ", 1, 86'(occ1), 86'(16));
        rdy[1] = 1'b1; tick();
        chk("t5_drop", 1, 86'(dc1), 86'(3));
        chk("t5_occ", 1, 86'(occ1), 86'(15));
        idle(1);
        for (int k = 0; k < 16; k++) tick();
        rdy[1] = 1'b0;

        // Flush discards contents and same-cycle pushes without counting drops.
        for (int k = 0; k < 2; k++) begin mv[0] = 4'b0011; tick(); end
        mv[0] = 4'b0001; tick();
        chk("t6_occ5", 0, 86'(occ0), 86'(5));
        fl[0] = 1'b1; tick();
        chk("t6_flush_occ", 0, 86'(occ0), 86'(0));
        chk("t6_flush_valid", 0, 86'(if0.trace_valid), 86'(0));
        chk("t6_flush_drop", 0, 86'(dc0), 86'(0));
        idle(0); mv[0] = 4'b0011; tick();

        // Asynchronous reset in the middle of a pop cycle.
        idle(0); rdy[0] = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", 0, 86'(if0.trace_valid), 86'(0));
        chk("rst_occ", 0, 86'(occ0), 86'(0));
        chk("rst_rec", 0, 86'(if0.trace_rec), 86'(0));
        chk("rst_drop", 1, 86'(dc1), 86'(0));
        chk("rst_cc", 1, 86'(cc1), 86'(0));
        mreset();
        @(negedge clk); rst = 1'b0;

        // Randomised traffic with alternating sink pressure and rare flushes.
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                idle(d);
                mv[d] = 4'($urandom_range(0, 15)) & ((d == 0) ? 4'b0011 : 4'b1111);
                if (mstall(d)) mv[d] = '0;
                rdy[d] = ($urandom_range(0, 99) < (((c / 200) % 2 == 0) ? 25 : 90));
                fl[d]  = ($urandom_range(0, 63) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
